ascii_to_binary: RTL and testbench
==================================

Name: ascii_to_binary

Overview:
Receives a stream of 7-bit ASCII characters ('0'/'1' plus a few control codes) and assembles them into a WIDTH-bit binary word. The first received digit is the MSB, so a word printed column by column (col 0 = MSB) reads back identically. Sits between the character input path (UART/keyboard front end) and the processor's word-load logic. Uses valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, number of bits in the assembled word (>=2)
CW, $clog2(WIDTH+1), width of the digit counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
char_in  input  7  ASCII character
char_valid  input  1  char_in is valid this cycle
char_ready  output  1  block can accept a character
word_out  output  WIDTH  assembled binary word
word_valid  output  1  word_out is valid; held until accepted
word_ready  input  1  consumer accepts word_out
count  output  CW  number of digits currently collected (0..WIDTH)
err  output  1  one-cycle pulse on overflow or illegal character

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=COLLECT, shift register=0, count=0, word_out=0, word_valid=0, err=0. char_ready=1 as soon as reset releases.
- States:
  - COLLECT: char_ready=1, word_valid=0.
  - OUTPUT: char_ready=0, word_valid=1.
- char_ready is a combinational decode of state only. It never depends on char_valid.
- A character is accepted in the cycle where char_valid && char_ready. Every effect below is registered and visible on the next cycle.
- '0' (7'd48) or '1' (7'd49):
  - If count < WIDTH: shift <= {shift[WIDTH-2:0], char_in[0]}; count+1.
  - If count == WIDTH: character dropped, shift and count unchanged, err=1 for one cycle.
- LF (7'd10) or CR (7'd13):
  - If count > 0: word_out <= shift, go to OUTPUT. The word is right-justified and zero-extended, because shift starts each word at 0.
  - If count == 0: ignored, no err. This lets a CR,LF pair produce a single word.
- Backspace (7'd8):
  - If count > 0: shift <= shift >> 1; count-1.
  - If count == 0: ignored, no err.
- Any other code: ignored, err=1 for one cycle.
- OUTPUT state:
  - word_out and word_valid are held stable until word_ready=1.
  - On the word_valid && word_ready cycle: shift<=0, count<=0, next state COLLECT. word_valid drops and char_ready rises on the following cycle.
  - Minimum gap between an accepted terminator and the next accepted char is 1 cycle plus the consumer delay.
- char_valid while in OUTPUT has no effect; upstream must hold the character.
- err pulses in consecutive cycles if bad characters arrive back-to-back. err never coincides with a state change to OUTPUT.
- count reflects the shift register at all times, including in OUTPUT (frozen value).
- Asynchronous reset mid-word or while in OUTPUT: the partial or pending word is discarded immediately and all outputs return to reset values.

Test Plan:
- Reset then send "1011\n" (WIDTH=8), word_ready=1 -> word_out=8'h0B, word_valid one cycle, count=4 while valid, then count=0, char_ready=1.
- Send "110", BS, "1", CR, LF with word_ready=0 for 5 cycles -> word_out=8'h07 held stable with word_valid=1 and char_ready=0 for all 5 cycles. The LF is only accepted after the handshake and is ignored (count=0, no err, no second word).
- Send nine '1's then LF (WIDTH=8) -> 9th char raises err for exactly 1 cycle, count stays 8, word_out=8'hFF.
- Send '2' (7'd50) and 'A' back-to-back -> err high 2 consecutive cycles, count=0, no word_valid.
- Send BS and LF with count=0 -> no err, no word_valid, state unchanged. Send "1" then assert rst_n=0 mid-stream -> count=0 and word_out=0 asynchronously. A following "1\n" yields word_out=1.
- WIDTH=32: send 32 digits of 32'hDEADBEEF MSB first, then CR -> word_out=32'hDEADBEEF, count=32.

Source files
------------

// File: rtl/ascii_to_binary.sv
// ascii_to_binary: assembles a stream of ASCII '0'/'1' characters into a binary word.
// The first digit received is the MSB; CR/LF terminates a word and BS deletes the last digit.
module ascii_to_binary #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CW-1:0]    count,
    output logic             err
);

    typedef enum logic {
        COLLECT,
        OUTPUT
    } state_t;

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_n;
    logic [WIDTH-1:0] word_n;
    logic [CW-1:0]    count_n;
    logic             err_n;
    logic             take;
    logic             is_digit;
    logic             is_term;
    logic             is_bs;

    assign char_ready = (state == COLLECT);
    assign word_valid = (state == OUTPUT);
    assign take       = char_valid && char_ready;
    assign is_digit   = (char_in == 7'd48) || (char_in == 7'd49);
    assign is_term    = (char_in == 7'd10) || (char_in == 7'd13);
    assign is_bs      = (char_in == 7'd8);

    // State, shift register, word and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            shift    <= '0;
            count    <= '0;
            word_out <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            count    <= count_n;
            word_out <= word_n;
            err      <= err_n;
        end
    end

    // Character decode and next-state logic; every path defaults to hold
    always_comb begin
        state_n = state;
        shift_n = shift;
        count_n = count;
        word_n  = word_out;
        err_n   = 1'b0;
        unique case (state)
            COLLECT: begin
                if (take) begin
                    unique case (1'b1)
                        is_digit: begin
                            if (count < FULL) begin
                                shift_n = {shift[WIDTH-2:0], char_in[0]};
                                count_n = count + CW'(1);
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                        is_term: begin
                            if (count != '0) begin
                                word_n  = shift;
                                state_n = OUTPUT;
                            end
                        end
                        is_bs: begin
                            if (count != '0) begin
                                shift_n = shift >> 1;
                                count_n = count - CW'(1);
                            end
                        end
                        default: err_n = 1'b1;
                    endcase
                end
            end
            OUTPUT: begin
                if (word_ready) begin
                    shift_n = '0;
                    count_n = '0;
                    state_n = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_ascii_to_binary.sv
// tb_ascii_to_binary: directed tests for ascii_to_binary at WIDTH=8 and WIDTH=32.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ascii_to_binary;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  char_in = 7'd0;
    logic        char_valid = 1'b0;
    logic        word_ready = 1'b0;
    logic        sel32 = 1'b0;

    logic        rdy8, wv8, err8;
    logic [7:0]  wo8;
    logic [3:0]  cnt8;
    logic        rdy32, wv32, err32;
    logic [31:0] wo32;
    logic [5:0]  cnt32;
    logic        rdy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rdy = sel32 ? rdy32 : rdy8;

    ascii_to_binary #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .char_in(char_in),
        .char_valid(char_valid && !sel32), .char_ready(rdy8),
        .word_out(wo8), .word_valid(wv8),
        .word_ready(word_ready && !sel32),
        .count(cnt8), .err(err8)
    );

    ascii_to_binary #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .char_in(char_in),
        .char_valid(char_valid && sel32), .char_ready(rdy32),
        .word_out(wo32), .word_valid(wv32),
        .word_ready(word_ready && sel32),
        .count(cnt32), .err(err32)
    );

    // Present one character at a falling edge and return at the falling edge after acceptance
    task automatic send(input logic [6:0] c);
        int n;
        n = 0;
        char_in = c;
        char_valid = 1'b1;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL send_timeout char=%0d char_ready stayed 0, required 1", c);
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wv8, err8, cnt8, wo8} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got wv=%b err=%b cnt=%0d wo=%h, required 0", wv8, err8, cnt8, wo8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rdy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b, required 1", rdy8);
        end
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send(7'd49); send(7'd48); send(7'd49); send(7'd49);
        send(7'd10);
        n_checks++;
        if (wv8 !== 1'b1 || wo8 !== 8'h0B || cnt8 !== 4'd4 || rdy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_word got wv=%b wo=%h cnt=%0d rdy=%b, required 1 0b 4 0", wv8, wo8, cnt8, rdy8);
        end
        @(negedge clk);
        n_checks++;
        if (wv8 !== 1'b0 || cnt8 !== 4'd0 || rdy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_after got wv=%b cnt=%0d rdy=%b, required 0 0 1", wv8, cnt8, rdy8);
        end
        word_ready = 1'b0;
    endtask

    task automatic test_backspace_hold();
        word_ready = 1'b0;
        send(7'd49); send(7'd49); send(7'd48);
        send(7'd8);
        n_checks++;
        if (cnt8 !== 4'd2) begin
            n_fail++;
            $display("FAIL bs_count got %0d, required 2", cnt8);
        end
        send(7'd49);
        send(7'd13);
        char_in = 7'd10;
        char_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (wv8 !== 1'b1 || wo8 !== 8'h07 || rdy8 !== 1'b0 || cnt8 !== 4'd3) begin
                n_fail++;
                $display("FAIL hold_cycle%0d got wv=%b wo=%h rdy=%b cnt=%0d, required 1 07 0 3", i, wv8, wo8, rdy8, cnt8);
            end
            @(negedge clk);
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        n_checks++;
        if (wv8 !== 1'b0 || rdy8 !== 1'b1 || cnt8 !== 4'd0) begin
            n_fail++;
            $display("FAIL hold_release got wv=%b rdy=%b cnt=%0d, required 0 1 0", wv8, rdy8, cnt8);
        end
        @(negedge clk);
        char_valid = 1'b0;
        n_checks++;
        if (wv8 !== 1'b0 || err8 !== 1'b0 || cnt8 !== 4'd0) begin
            n_fail++;
            $display("FAIL lf_ignored got wv=%b err=%b cnt=%0d, required 0 0 0", wv8, err8, cnt8);
        end
        @(negedge clk);
        n_checks++;
        if (wv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL no_second_word got wv=%b, required 0", wv8);
        end
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(7'd49);
        n_checks++;
        if (err8 !== 1'b0 || cnt8 !== 4'd8) begin
            n_fail++;
            $display("FAIL full_count got err=%b cnt=%0d, required 0 8", err8, cnt8);
        end
        send(7'd49);
        n_checks++;
        if (err8 !== 1'b1 || cnt8 !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow_err got err=%b cnt=%0d, required 1 8", err8, cnt8);
        end
        @(negedge clk);
        n_checks++;
        if (err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pulse got err=%b, required 0", err8);
        end
        send(7'd10);
        n_checks++;
        if (wv8 !== 1'b1 || wo8 !== 8'hFF || cnt8 !== 4'd8 || err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_word got wv=%b wo=%h cnt=%0d err=%b, required 1 ff 8 0", wv8, wo8, cnt8, err8);
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    task automatic test_back_to_back_err();
        send(7'd50);
        n_checks++;
        if (err8 !== 1'b1) begin
            n_fail++;
            $display("FAIL bad1_err got %b, required 1", err8);
        end
        send(7'd65);
        n_checks++;
        if (err8 !== 1'b1 || cnt8 !== 4'd0 || wv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bad2_err got err=%b cnt=%0d wv=%b, required 1 0 0", err8, cnt8, wv8);
        end
        @(negedge clk);
        n_checks++;
        if (err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_pulse_end got err=%b, required 0", err8);
        end
    endtask

    task automatic test_empty_and_reset();
        send(7'd8);
        n_checks++;
        if (err8 !== 1'b0 || wv8 !== 1'b0 || cnt8 !== 4'd0 || rdy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_bs got err=%b wv=%b cnt=%0d rdy=%b, required 0 0 0 1", err8, wv8, cnt8, rdy8);
        end
        send(7'd10);
        n_checks++;
        if (err8 !== 1'b0 || wv8 !== 1'b0 || rdy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_lf got err=%b wv=%b rdy=%b, required 0 0 1", err8, wv8, rdy8);
        end
        send(7'd49);
        n_checks++;
        if (cnt8 !== 4'd1 || wo8 !== 8'hFF) begin
            n_fail++;
            $display("FAIL pre_reset got cnt=%0d wo=%h, required 1 ff", cnt8, wo8);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cnt8 !== 4'd0 || wo8 !== 8'h00 || wv8 !== 1'b0 || rdy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset got cnt=%0d wo=%h wv=%b rdy=%b, required 0 00 0 1", cnt8, wo8, wv8, rdy8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(7'd49);
        send(7'd10);
        n_checks++;
        if (wv8 !== 1'b1 || wo8 !== 8'h01 || cnt8 !== 4'd1) begin
            n_fail++;
            $display("FAIL after_reset_word got wv=%b wo=%h cnt=%0d, required 1 01 1", wv8, wo8, cnt8);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (wv8 !== 1'b0 || wo8 !== 8'h00 || rdy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_output got wv=%b wo=%h rdy=%b, required 0 00 1", wv8, wo8, rdy8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_width32();
        logic [31:0] v;
        v = 32'hDEADBEEF;
        sel32 = 1'b1;
        word_ready = 1'b0;
        for (int i = 31; i >= 0; i--) send(v[i] ? 7'd49 : 7'd48);
        send(7'd13);
        n_checks++;
        if (wv32 !== 1'b1 || wo32 !== 32'hDEADBEEF || cnt32 !== 6'd32 || err32 !== 1'b0) begin
            n_fail++;
            $display("FAIL w32_word got wv=%b wo=%h cnt=%0d err=%b, required 1 deadbeef 32 0", wv32, wo32, cnt32, err32);
        end
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        n_checks++;
        if (wv32 !== 1'b0 || cnt32 !== 6'd0 || rdy32 !== 1'b1) begin
            n_fail++;
            $display("FAIL w32_after got wv=%b cnt=%0d rdy=%b, required 0 0 1", wv32, cnt32, rdy32);
        end
        sel32 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backspace_hold();
        test_overflow();
        test_back_to_back_err();
        test_empty_and_reset();
        test_width32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
